// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM state encoding
// and output-shape mode constants.
package clk_div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter: counts 0..limit, flags the last cycle of a period (wrap)
// and returns to 0 on the following edge.
module clk_div_cnt #(
  parameter int unsigned N = 26
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         clear,
  input  logic [N-1:0] limit,
  output logic [N-1:0] count,
  output logic         wrap
);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;

  assign wrap  = (count_q == limit);
  assign count = count_q;

  // next count: clear has priority over counting
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (wrap) begin
        count_d = '0;
      end else begin
        count_d = count_q + N'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: square-wave or single-pulse output with a
// period-start tick; divisor and mode updates are deferred to period boundaries.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned N       = 26,
  parameter int unsigned DEF_DIV = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] div_in,
  input  logic         load,
  output logic         clk_out,
  output logic         tick,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [N-1:0] div_act_q, div_act_d;
  logic [N-1:0] pend_val_q, pend_val_d;
  logic         pend_q, pend_d;
  logic         mode_act_q, mode_act_d;
  logic         clk_out_q, clk_out_d;
  logic         tick_q, tick_d;
  logic         busy_q, busy_d;

  logic         run_s;
  logic [N-1:0] cnt_s;
  logic         cnt_wrap_s;
  logic [N-1:0] cnt_limit_s;

  // Last count of a period; divisors 0 and 1 behave as 2.
  function automatic logic [N-1:0] limit_of(input logic [N-1:0] d);
    if (d < N'(2)) begin
      return N'(1);
    end else begin
      return d - N'(1);
    end
  endfunction

  // Number of high cycles in square mode, (P_eff+1)>>1, one bit wider to avoid overflow.
  function automatic logic [N:0] high_of(input logic [N-1:0] d);
    logic [N:0] p;
    p = (d < N'(2)) ? (N+1)'(2) : {1'b0, d};
    return (p + (N+1)'(1)) >> 1'b1;
  endfunction

  assign run_s       = (state_q == ST_RUN) && en;
  assign cnt_limit_s = limit_of(div_act_q);

  clk_div_cnt #(.N(N)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (run_s),
    .clear   (!run_s),
    .limit   (cnt_limit_s),
    .count   (cnt_s),
    .wrap    (cnt_wrap_s)
  );

  // next-state, divisor/mode staging and output values for the coming cycle
  always_comb begin
    state_d    = state_q;
    div_act_d  = div_act_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    mode_act_d = mode_act_q;
    clk_out_d  = 1'b0;
    tick_d     = 1'b0;
    busy_d     = 1'b0;
    if (load) begin
      pend_val_d = div_in;
      pend_d     = 1'b1;
    end else begin
      pend_val_d = pend_val_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          div_act_d = pend_val_q;
          pend_d    = load;
        end else begin
          div_act_d = div_act_q;
        end
        mode_act_d = mode;
        if (en) begin
          state_d   = ST_RUN;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
          busy_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (cnt_wrap_s) begin
          // new period starts at cnt 0, where both shapes are high
          busy_d     = 1'b1;
          clk_out_d  = 1'b1;
          tick_d     = 1'b1;
          mode_act_d = mode;
          pend_d     = 1'b0;
          if (load) begin
            div_act_d = div_in;
          end else if (pend_q) begin
            div_act_d = pend_val_q;
          end else begin
            div_act_d = div_act_q;
          end
        end else begin
          busy_d    = 1'b1;
          clk_out_d = (mode_act_q == MODE_SQUARE) &&
                      (({1'b0, cnt_s} + (N+1)'(1)) < high_of(div_act_q));
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      div_act_q  <= N'(DEF_DIV);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      mode_act_q <= MODE_SQUARE;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_act_q  <= div_act_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      mode_act_q <= mode_act_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed vector table, hand-written
// corner sequences, then random stimulus against a period-level reference model.
module tb_clk_div_prog;

  localparam int N = 26;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en;
  logic         mode;
  logic         load;
  logic [N-1:0] div_in;
  logic         clk_out;
  logic         tick;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_prog #(.N(N), .DEF_DIV(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .mode    (mode),
    .div_in  (div_in),
    .load    (load),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  typedef struct {
    bit en;
    bit mode;
    bit load;
    int div;
    bit e_clk;
    bit e_tick;
    bit e_busy;
  } vec_t;

  vec_t tbl[$];

  // reference model: run flag, position within the current output period,
  // divisor/mode in force for this period, and the last unapplied load
  int m_run, m_phase, m_div, m_mode, m_pend, m_pval;

  function automatic int peff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    m_run = 0; m_phase = 0; m_div = 8; m_mode = 0; m_pend = 0; m_pval = 0;
  endtask

  task automatic model_step(input bit e, input bit md, input bit ld, input int dv);
    bit consumed;
    consumed = 1'b0;
    if (m_run == 0) begin
      if (m_pend != 0) begin
        m_div  = m_pval;
        m_pend = 0;
      end
      m_mode = md;
      if (e) begin
        m_run   = 1;
        m_phase = 0;
      end
    end else if (!e) begin
      m_run   = 0;
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
      if (m_phase == peff(m_div)) begin
        m_phase = 0;
        m_mode  = md;
        if (ld) begin
          m_div    = dv;
          consumed = 1'b1;
        end else if (m_pend != 0) begin
          m_div = m_pval;
        end
        m_pend = 0;
      end
    end
    if (ld && !consumed) begin
      m_pend = 1;
      m_pval = dv;
    end
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input bit c, input bit t, input bit b);
    chk({tag, ".clk_out"}, clk_out, c);
    chk({tag, ".tick"}, tick, t);
    chk({tag, ".busy"}, busy, b);
  endtask

  task automatic drive_cycle(input bit e, input bit md, input bit ld, input int dv);
    en = e; mode = md; load = ld; div_in = N'(dv);
    @(posedge clk);
    #1;
    model_step(e, md, ld, dv);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; div_in = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic add(input bit e, input bit md, input bit ld, input int dv,
                     input bit c, input bit t, input bit b);
    vec_t v;
    v.en = e; v.mode = md; v.load = ld; v.div = dv;
    v.e_clk = c; v.e_tick = t; v.e_busy = b;
    tbl.push_back(v);
  endtask

  initial begin
    bit rmode;
    model_reset();

    // default divisor 8, square wave, from reset release
    for (int p = 0; p < 19; p++) add(1, 0, 0, 0, (p % 8) < 4, (p % 8) == 0, 1);
    // load 5 seen at cnt=2: current 8-cycle period completes
    add(1, 0, 1, 5, 1, 0, 1);
    for (int p = 4; p < 8; p++) add(1, 0, 0, 0, 0, 0, 1);
    // new periods of 5: three high, two low
    for (int p = 0; p < 9; p++) add(1, 0, 0, 0, (p % 5) < 3, (p % 5) == 0, 1);
    // en drops with cnt=3, then re-enable restarts at cnt 0
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 1, 0, 1);

    do_reset();
    foreach (tbl[i]) begin
      drive_cycle(tbl[i].en, tbl[i].mode, tbl[i].load, tbl[i].div);
      check_outs($sformatf("vec%0d", i), tbl[i].e_clk, tbl[i].e_tick, tbl[i].e_busy);
    end

    // divisor 0 then 1: both behave as 2
    drive_cycle(0, 0, 1, 0);
    drive_cycle(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, 0, 0, 0);
      check_outs($sformatf("div0_%0d", i), (i % 2) == 0, (i % 2) == 0, 1);
    end
    drive_cycle(0, 0, 1, 1);
    drive_cycle(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, 0, 0, 0);
      check_outs($sformatf("div1_%0d", i), (i % 2) == 0, (i % 2) == 0, 1);
    end

    // pulse mode with divisor 4
    drive_cycle(0, 1, 1, 4);
    drive_cycle(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1, 1, 0, 0);
      check_outs($sformatf("pulse4_%0d", i), (i % 4) == 0, (i % 4) == 0, 1);
    end

    // asynchronous reset mid-period: outputs clear without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1, 0, 0, 0);
      check_outs($sformatf("post_rst_%0d", i), i < 4, i == 0, 1);
    end
    // load on the boundary cycle applies to the period starting at that edge
    drive_cycle(1, 0, 1, 3);
    check_outs("bnd_load_0", 1, 1, 1);
    drive_cycle(1, 0, 0, 0);
    check_outs("bnd_load_1", 1, 0, 1);
    drive_cycle(1, 0, 0, 0);
    check_outs("bnd_load_2", 0, 0, 1);
    drive_cycle(1, 0, 0, 0);
    check_outs("bnd_load_3", 1, 1, 1);

    // random stimulus against the reference model
    do_reset();
    rmode = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      bit e, ld;
      int dv;
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        #2;
        check_outs($sformatf("rnd_rst_%0d", i), 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        model_reset();
      end
      e  = ($urandom_range(0, 24) != 0);
      ld = ($urandom_range(0, 9) == 0);
      dv = $urandom_range(0, 12);
      if ($urandom_range(0, 39) == 0) rmode = ~rmode;
      drive_cycle(e, rmode, ld, dv);
      check_outs($sformatf("rnd%0d", i),
                 (m_run != 0) && ((m_mode != 0) ? (m_phase == 0)
                                                : (m_phase < (peff(m_div) + 1) / 2)),
                 (m_run != 0) && (m_phase == 0),
                 m_run != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
